// File: rtl/fmps_test_link_checker.sv
// Consumer of the FMPS test-link stream: checks framing, field contents and per-session sequencing
// of two-word packets, and reports per-packet verdicts, a session index bitmap and saturating counts.
module fmps_test_link_checker #(
    parameter logic [15:0] DATA_MAGIC          = 16'hCACA,
    parameter logic [15:0] HEADER_MAGIC        = 16'hB6CF,
    parameter string       CHECK_CYCLE_COUNTER = "true",
    parameter int unsigned COUNTER_WIDTH       = 16
) (
    input  logic                     auroraUserClk,
    input  logic                     auroraReset,
    input  logic                     auroraFAstrobe,
    input  logic                     clearCounters,
    input  logic [31:0]              FMPS_TEST_AXI_STREAM_RX_tdata,
    input  logic                     FMPS_TEST_AXI_STREAM_RX_tvalid,
    input  logic                     FMPS_TEST_AXI_STREAM_RX_tlast,
    output logic                     FMPS_TEST_AXI_STREAM_RX_tready,
    output logic                     statusStrobe,
    output logic [1:0]               statusCode,
    output logic [4:0]               statusIndex,
    output logic [31:0]              sessionBitmap,
    output logic                     sessionDone,
    output logic [COUNTER_WIDTH-1:0] goodCount,
    output logic [COUNTER_WIDTH-1:0] errorCount
);

    localparam int unsigned IdxW = 5;
    localparam int unsigned CycW = 8;
    localparam bit CheckCounter = (CHECK_CYCLE_COUNTER == "true");

    typedef logic [COUNTER_WIDTH-1:0] countT;
    typedef enum logic [1:0] {WAIT_HEADER, WAIT_DATA, DRAIN} stateT;
    typedef enum logic [1:0] {
        CODE_OK       = 2'd0,
        CODE_FRAMING  = 2'd1,
        CODE_CONTENT  = 2'd2,
        CODE_SEQUENCE = 2'd3
    } codeT;

    stateT           state;
    stateT           stateNext;
    stateT           stateEff;
    logic [IdxW-1:0] hdrIndex;
    logic [31:0]     liveBitmap;
    logic            counterSeen;
    logic            counterValid;
    logic [CycW-1:0] sessionCounter;

    logic            beat;
    logic [IdxW-1:0] rxHdrIndex;
    logic [IdxW-1:0] rxDataIndex;
    logic [CycW-1:0] rxCycle;
    logic            hdrFieldsOk;
    logic            dataFieldsOk;
    logic            seqViolation;
    logic            verdictValid;
    codeT            verdictCode;
    logic [IdxW-1:0] verdictIndex;
    logic            latchHdr;
    logic            acceptOk;

    assign beat        = FMPS_TEST_AXI_STREAM_RX_tvalid && FMPS_TEST_AXI_STREAM_RX_tready;
    assign rxHdrIndex  = FMPS_TEST_AXI_STREAM_RX_tdata[14:10];
    assign rxDataIndex = FMPS_TEST_AXI_STREAM_RX_tdata[28:24];
    assign rxCycle     = FMPS_TEST_AXI_STREAM_RX_tdata[7:0];

    assign hdrFieldsOk  = (FMPS_TEST_AXI_STREAM_RX_tdata[31:16] == HEADER_MAGIC)
                       && FMPS_TEST_AXI_STREAM_RX_tdata[15]
                       && (FMPS_TEST_AXI_STREAM_RX_tdata[9:0] == '0);
    assign dataFieldsOk = (FMPS_TEST_AXI_STREAM_RX_tdata[31:29] == '0)
                       && (rxDataIndex == hdrIndex)
                       && (FMPS_TEST_AXI_STREAM_RX_tdata[23:8] == DATA_MAGIC);

    // Duplicate index, counter drift within a session, or a broken session-to-session counter step
    assign seqViolation = liveBitmap[hdrIndex]
                       || (counterSeen && (rxCycle != sessionCounter))
                       || (CheckCounter && counterValid && !counterSeen
                           && (rxCycle != CycW'(sessionCounter + CycW'(1))));

    // A session strobe abandons any partial packet and parses the same-cycle beat as a header
    always_comb begin
        stateEff     = auroraFAstrobe ? WAIT_HEADER : state;
        stateNext    = stateEff;
        verdictValid = 1'b0;
        verdictCode  = CODE_OK;
        verdictIndex = hdrIndex;
        latchHdr     = 1'b0;
        acceptOk     = 1'b0;
        if (beat) begin
            case (stateEff)
                WAIT_HEADER: begin
                    verdictIndex = rxHdrIndex;
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        verdictValid = 1'b1;
                        verdictCode  = CODE_FRAMING;
                    end else if (!hdrFieldsOk) begin
                        verdictValid = 1'b1;
                        verdictCode  = CODE_CONTENT;
                        stateNext    = DRAIN;
                    end else begin
                        latchHdr  = 1'b1;
                        stateNext = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    verdictValid = 1'b1;
                    stateNext    = WAIT_HEADER;
                    if (!FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        verdictCode = CODE_FRAMING;
                        stateNext   = DRAIN;
                    end else if (!dataFieldsOk) begin
                        verdictCode = CODE_CONTENT;
                    end else if (seqViolation) begin
                        verdictCode = CODE_SEQUENCE;
                    end else begin
                        acceptOk = 1'b1;
                    end
                end
                DRAIN: begin
                    if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                        stateNext = WAIT_HEADER;
                    end
                end
                default: stateNext = WAIT_HEADER;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            state                          <= WAIT_HEADER;
            hdrIndex                       <= '0;
            liveBitmap                     <= '0;
            counterSeen                    <= 1'b0;
            counterValid                   <= 1'b0;
            sessionCounter                 <= '0;
            FMPS_TEST_AXI_STREAM_RX_tready <= 1'b0;
            statusStrobe                   <= 1'b0;
            statusCode                     <= '0;
            statusIndex                    <= '0;
            sessionBitmap                  <= '0;
            sessionDone                    <= 1'b0;
            goodCount                      <= '0;
            errorCount                     <= '0;
        end else begin
            state                          <= stateNext;
            FMPS_TEST_AXI_STREAM_RX_tready <= 1'b1;
            statusStrobe                   <= verdictValid;
            sessionDone                    <= auroraFAstrobe;
            if (verdictValid) begin
                statusCode  <= verdictCode;
                statusIndex <= verdictIndex;
            end
            if (latchHdr) begin
                hdrIndex <= rxHdrIndex;
            end

            // The last session counter survives the strobe for the continuity check
            if (auroraFAstrobe) begin
                sessionBitmap <= liveBitmap;
                liveBitmap    <= '0;
                counterSeen   <= 1'b0;
            end else if (acceptOk) begin
                liveBitmap[hdrIndex] <= 1'b1;
                counterValid         <= 1'b1;
                if (!counterSeen) begin
                    counterSeen    <= 1'b1;
                    sessionCounter <= rxCycle;
                end
            end

            if (clearCounters) begin
                goodCount  <= '0;
                errorCount <= '0;
            end else if (verdictValid) begin
                if (verdictCode == CODE_OK) begin
                    if (!(&goodCount)) begin
                        goodCount <= goodCount + countT'(1);
                    end
                end else if (!(&errorCount)) begin
                    errorCount <= errorCount + countT'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// Directed bench for fmps_test_link_checker: a packet-level reference model checked every cycle,
// plus literal expectations at key points.
module tb_fmps_test_link_checker;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          strobe;
    logic          clr;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          statusStrobe;
    logic [1:0]    statusCode;
    logic [4:0]    statusIndex;
    logic [31:0]   sessionBitmap;
    logic          sessionDone;
    logic [CW-1:0] goodCount;
    logic [CW-1:0] errorCount;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fmps_test_link_checker #(
        .DATA_MAGIC          (16'hCACA),
        .HEADER_MAGIC        (16'hB6CF),
        .CHECK_CYCLE_COUNTER ("true"),
        .COUNTER_WIDTH       (CW)
    ) dut (
        .auroraUserClk                  (clk),
        .auroraReset                    (rst),
        .auroraFAstrobe                 (strobe),
        .clearCounters                  (clr),
        .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
        .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
        .FMPS_TEST_AXI_STREAM_RX_tready (tready),
        .statusStrobe                   (statusStrobe),
        .statusCode                     (statusCode),
        .statusIndex                    (statusIndex),
        .sessionBitmap                  (sessionBitmap),
        .sessionDone                    (sessionDone),
        .goodCount                      (goodCount),
        .errorCount                     (errorCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] hdr(input logic [4:0] idx);
        return {16'hB6CF, 1'b1, idx, 10'b0};
    endfunction

    function automatic logic [31:0] dat(input logic [4:0] idx, input logic [7:0] cnt);
        return {3'b000, idx, 16'hCACA, cnt};
    endfunction

    // Reference model: packet rules applied per accepted beat
    bit          mReady, mStrobe, mDone;
    int          mCode, mIdx, mGood, mBad;
    logic [31:0] mMap;
    bit          expData, dropping;
    int          hdrIdx, firstCnt, prevCnt;
    bit [31:0]   got;

    always @(posedge clk) begin : model
        bit acc;
        bit v;
        int code;
        int vIdx;
        int cnt;
        acc = tvalid && mReady;
        if (rst) begin
            mReady = 0; mStrobe = 0; mDone = 0; mCode = 0; mIdx = 0;
            mGood = 0; mBad = 0; mMap = '0; expData = 0; dropping = 0;
            hdrIdx = 0; firstCnt = -1; prevCnt = -1; got = '0;
        end else begin
            mReady = 1;
            v = 0; code = 0; vIdx = 0;
            mDone = strobe;
            if (strobe) begin
                mMap = got;
                got = '0;
                if (firstCnt >= 0) prevCnt = firstCnt;
                firstCnt = -1;
                expData = 0;
                dropping = 0;
            end
            if (acc) begin
                if (dropping) begin
                    if (tlast) dropping = 0;
                end else if (!expData) begin
                    vIdx = int'(tdata[14:10]);
                    if (tlast) begin
                        v = 1; code = 1;
                    end else if (tdata[31:16] != 16'hB6CF || !tdata[15] || tdata[9:0] != 10'd0) begin
                        v = 1; code = 2; dropping = 1;
                    end else begin
                        expData = 1; hdrIdx = vIdx;
                    end
                end else begin
                    v = 1; vIdx = hdrIdx; expData = 0;
                    cnt = int'(tdata[7:0]);
                    if (!tlast) begin
                        code = 1; dropping = 1;
                    end else if (tdata[31:29] != 3'd0 || int'(tdata[28:24]) != hdrIdx
                                 || tdata[23:8] != 16'hCACA) begin
                        code = 2;
                    end else if (got[hdrIdx] || (firstCnt >= 0 && cnt != firstCnt)
                                 || (firstCnt < 0 && prevCnt >= 0 && cnt != (prevCnt + 1) % 256)) begin
                        code = 3;
                    end else begin
                        code = 0;
                        got[hdrIdx] = 1'b1;
                        if (firstCnt < 0) firstCnt = cnt;
                    end
                end
            end
            mStrobe = v;
            if (v) begin
                mCode = code;
                mIdx = vIdx;
                if (code == 0) mGood = (mGood < SAT) ? mGood + 1 : SAT;
                else           mBad  = (mBad  < SAT) ? mBad  + 1 : SAT;
            end
            if (clr) begin
                mGood = 0;
                mBad = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        check("tready",        32'(tready),        32'(mReady));
        check("statusStrobe",  32'(statusStrobe),  32'(mStrobe));
        check("statusCode",    32'(statusCode),    32'(mCode));
        check("statusIndex",   32'(statusIndex),   32'(mIdx));
        check("sessionBitmap", sessionBitmap,      mMap);
        check("sessionDone",   32'(sessionDone),   32'(mDone));
        check("goodCount",     32'(goodCount),     32'(mGood));
        check("errorCount",    32'(errorCount),    32'(mBad));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        tdata = d; tvalid = 1'b1; tlast = last;
        cycle();
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic fastrobe();
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
    endtask

    task automatic expectVerdict(input string name, input int code, input int idx);
        check({name, " strobe"}, 32'(statusStrobe), 32'd1);
        check({name, " code"},   32'(statusCode),   32'(code));
        check({name, " index"},  32'(statusIndex),  32'(idx));
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) cycle();
        check("tready in reset", 32'(tready), 32'd0);
        rst = 1'b0;
        cycle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1; strobe = 1'b0; clr = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        doReset();
        check("reset tready",     32'(tready),     32'd1);
        check("reset goodCount",  32'(goodCount),  32'd0);
        check("reset errorCount", 32'(errorCount), 32'd0);
        check("reset bitmap",     sessionBitmap,   32'd0);

        // Session A: one good packet, index 3, counter 1
        fastrobe();
        beat(32'hB6CF8C00, 1'b0);
        beat(32'h03CACA01, 1'b1);
        expectVerdict("first ok", 0, 3);
        check("first goodCount", 32'(goodCount), 32'd1);
        fastrobe();
        check("session A bitmap", sessionBitmap, 32'h0000_0008);
        check("session A done",   32'(sessionDone), 32'd1);

        // Session B: continuity, duplicates, counter drift
        beat(hdr(3), 1'b0); beat(dat(3, 8'h03), 1'b1);
        expectVerdict("continuity break", 3, 3);
        beat(hdr(3), 1'b0); beat(dat(3, 8'h02), 1'b1);
        expectVerdict("continuity ok", 0, 3);
        beat(hdr(3), 1'b0); beat(dat(3, 8'h02), 1'b1);
        expectVerdict("duplicate", 3, 3);
        beat(hdr(9), 1'b0); beat(dat(9, 8'h07), 1'b1);
        expectVerdict("counter drift", 3, 9);

        // Framing errors and drain
        beat(hdr(5), 1'b1);
        expectVerdict("header tlast", 1, 5);
        beat(hdr(5), 1'b0); beat(dat(5, 8'h02), 1'b0);
        expectVerdict("data no tlast", 1, 5);
        beat(32'h1234_5678, 1'b0);
        check("drain quiet 1", 32'(statusStrobe), 32'd0);
        beat(32'h0000_0000, 1'b1);
        check("drain quiet 2", 32'(statusStrobe), 32'd0);
        beat(hdr(5), 1'b0); beat(dat(5, 8'h02), 1'b1);
        expectVerdict("after drain ok", 0, 5);

        // Content errors
        beat(hdr(7), 1'b0); beat(dat(4, 8'h02), 1'b1);
        expectVerdict("data index", 2, 7);
        beat(hdr(7), 1'b0); beat({3'b000, 5'd7, 16'hCACB, 8'h02}, 1'b1);
        expectVerdict("data magic", 2, 7);
        beat(32'hB6CE8C00, 1'b0);
        expectVerdict("header magic", 2, 3);
        beat(32'h0000_0000, 1'b1);
        fastrobe();
        check("session B bitmap", sessionBitmap, 32'h0000_0028);

        // Strobe between header and data abandons the packet silently
        beat(hdr(2), 1'b0);
        fastrobe();
        check("abandon quiet",    32'(statusStrobe), 32'd0);
        check("abandon bitmap",   sessionBitmap,     32'd0);

        // Header accepted in the strobe cycle belongs to the new session
        strobe = 1'b1; tdata = hdr(4); tvalid = 1'b1; tlast = 1'b0;
        cycle();
        strobe = 1'b0; tdata = '0; tvalid = 1'b0;
        beat(dat(4, 8'h03), 1'b1);
        expectVerdict("header in strobe cycle", 0, 4);
        check("goodCount 4", 32'(goodCount), 32'd4);

        // Saturate errorCount
        for (int i = 0; i < 9; i++) beat(hdr(1), 1'b1);
        check("errorCount saturated", 32'(errorCount), 32'(SAT));
        beat(hdr(1), 1'b1);
        check("errorCount holds", 32'(errorCount), 32'(SAT));

        // Clear wins over a simultaneous increment
        beat(hdr(6), 1'b0);
        clr = 1'b1;
        beat(dat(6, 8'h03), 1'b1);
        clr = 1'b0;
        expectVerdict("clear with verdict", 0, 6);
        check("cleared goodCount",  32'(goodCount),  32'd0);
        check("cleared errorCount", 32'(errorCount), 32'd0);

        // Reset mid-packet
        beat(hdr(8), 1'b0);
        doReset();
        check("mid reset strobe", 32'(statusStrobe), 32'd0);
        check("mid reset bitmap", sessionBitmap,     32'd0);
        beat(hdr(8), 1'b0); beat(dat(8, 8'h55), 1'b1);
        expectVerdict("post reset ok", 0, 8);
        check("post reset goodCount", 32'(goodCount), 32'd1);

        cycle();
        cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fmps_test_link_checker.md
Name: fmps_test_link_checker

Overview:
- Downstream consumer of the FMPS test-link AXI stream produced by the dummy-packet writer.
- Sits at the Aurora RX side, or directly on the writer's output in loopback builds, all in the Aurora user clock domain.
- Parses each two-word FMPS packet, checks framing, field contents and per-session sequencing, and reports per-packet status.
- Accumulates a per-FA-session bitmap of received FMPS indices plus saturating good/error counters for CSR readout.

Parameters:
- DATA_MAGIC, 16'hCACA, magic expected in data word bits [23:8].
- HEADER_MAGIC, 16'hB6CF, magic expected in header bits [31:16].
- CHECK_CYCLE_COUNTER, "true", "true"/"false"; enables the cross-session cycle-counter continuity check.
- COUNTER_WIDTH, 16, width of the good and error counters.

Ports:
- auroraUserClk  in  1  sole clock.
- auroraReset  in  1  synchronous, active-high reset.
- auroraFAstrobe  in  1  start of new FA session.
- clearCounters  in  1  synchronous clear of goodCount and errorCount.
- FMPS_TEST_AXI_STREAM_RX_tdata  in  32  stream data.
- FMPS_TEST_AXI_STREAM_RX_tvalid  in  1  stream valid.
- FMPS_TEST_AXI_STREAM_RX_tlast  in  1  last word of packet.
- FMPS_TEST_AXI_STREAM_RX_tready  out  1  ready.
- statusStrobe  out  1  one-cycle pulse per packet verdict.
- statusCode  out  2  0 OK, 1 framing, 2 content, 3 sequence.
- statusIndex  out  5  FMPS index from header of judged packet.
- sessionBitmap  out  32  indices received OK in the previous session.
- sessionDone  out  1  pulse when sessionBitmap updates.
- goodCount  out  COUNTER_WIDTH  saturating count of OK packets.
- errorCount  out  COUNTER_WIDTH  saturating count of non-OK packets.

Behaviour:
- Single clock auroraUserClk; synchronous active-high reset auroraReset.
- Reset values: all outputs 0, tready 0, state WAIT_HEADER, live bitmap 0, counterValid 0.
- tready = 1 whenever not in reset; the block never backpressures. A beat is accepted when tvalid && tready.
- Header format:
  - [31:16] = HEADER_MAGIC.
  - [15] = 1 (enabled).
  - [14:10] = index.
  - [9:0] = 0.
- Data format:
  - [31:29] = 0.
  - [28:24] = index, must equal the header index.
  - [23:8] = DATA_MAGIC.
  - [7:0] = FA cycle counter.
- States:
  - WAIT_HEADER, header beat:
    - tlast=1 -> verdict framing; stay in WAIT_HEADER.
    - Field mismatch -> verdict content; go to DRAIN.
    - Otherwise latch index; go to WAIT_DATA.
  - WAIT_DATA, data beat:
    - tlast=0 -> verdict framing; go to DRAIN.
    - Field mismatch -> verdict content; go to WAIT_HEADER.
    - Sequence violation -> verdict sequence; go to WAIT_HEADER.
    - Otherwise verdict OK, set bitmap bit[index]; go to WAIT_HEADER.
  - DRAIN: discard beats until a beat with tlast=1 is accepted, then go to WAIT_HEADER. No further verdicts for that packet.
- Verdict priority: framing > content > sequence.
- Sequence violations:
  - Index bit already set in the live bitmap (duplicate).
  - Cycle counter differs from the first OK counter of this session.
  - When CHECK_CYCLE_COUNTER is enabled and counterValid=1: first counter of the session != previous session counter + 1, mod 256.
- Verdict latency: statusStrobe/statusCode/statusIndex are registered, one cycle after the deciding beat. statusIndex = 0 for header-stage verdicts when the header is unparseable? No: statusIndex always carries the raw header bits [14:10].
- auroraFAstrobe:
  - sessionBitmap <= live bitmap; sessionDone pulses the next cycle.
  - Live bitmap and session-counter-seen are cleared; the last session counter is kept.
  - State forced to WAIT_HEADER; any partial packet is abandoned silently, with no verdict.
  - A beat accepted in the same cycle is treated as a header of the new session.
- counterValid sets on the first OK packet after reset and stays set. The continuity check is skipped while counterValid=0.
- Counters: +1 on each statusStrobe (good if code 0, else error) and saturate at all-ones. clearCounters wins over a simultaneous increment.
- Reset mid-packet: immediate return to reset values; no verdict issued.

Test Plan:
- Session strobe, then header 0xB6CF8C00 (idx 3), then data 0x03CACA01 with tlast -> one cycle later statusStrobe, code 0, index 3, goodCount 1. Next strobe -> sessionBitmap 0x00000008, sessionDone pulse.
- Header sent with tlast=1 -> code 1. Then data 0x0xCACA.. without tlast followed by 2 junk beats, last with tlast -> exactly one code-1 verdict; the next good packet returns code 0.
- Data word index 4 after header index 3, or magic 0xCACB -> code 2, errorCount 1, bitmap unchanged.
- Two OK packets with idx 3 in one session -> second gives code 3. Next session with counter 0x03 after 0x01 -> code 3; with 0x02 -> code 0.
- Strobe asserted between header and data -> no verdict, state WAIT_HEADER. A header accepted in the strobe cycle is parsed normally.
- Preload errorCount to all-ones and send a bad packet -> count holds. Assert clearCounters together with a verdict -> both counters read 0.
